matmul_feeder: RTL and testbench

Operand loader and skew sequencer that sits directly upstream of the 2x2 output-stationary systolic multiplier. It accepts two 2x2 unsigned 8-bit matrices as a byte stream over a valid/ready handshake and buffers all eight operands. It then pulses the multiplier's start input and drives the four diagonally-skewed operand buses for exactly four cycles. It flags when the multiplier's four 16-bit accumulators hold the final product C = A x B.

---
 rtl/matmul_feeder.sv | 117 +++++++++++
 tb/tb_matmul_feeder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_feeder.sv
// Operand loader and skew sequencer for a 2x2 output-stationary systolic multiplier.
// Buffers A and B from a byte stream, then drives diagonally-skewed operand buses for four cycles.
module matmul_feeder (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       mm_start,
  output logic [7:0] A_cell_1,
  output logic [7:0] A_cell_2,
  output logic [7:0] B_cell_1,
  output logic [7:0] B_cell_2,
  output logic       busy,
  output logic       result_valid
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    START = 3'd1,
    FEED0 = 3'd2,
    FEED1 = 3'd3,
    FEED2 = 3'd4,
    FEED3 = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                   state;
  logic [2:0]               count;
  // Slots 0..3 hold A00,A01,A10,A11; slots 4..7 hold B00,B01,B10,B11.
  logic [7:0][DATA_W-1:0]   operand_buf;
  logic                     accept;

  assign accept = load_valid && load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD;
      count        <= 3'd0;
      operand_buf  <= '0;
      load_ready   <= 1'b1;
      mm_start     <= 1'b0;
      A_cell_1     <= '0;
      A_cell_2     <= '0;
      B_cell_1     <= '0;
      B_cell_2     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      // Buses and start default to idle; each state below sets the values for the next cycle.
      mm_start <= 1'b0;
      A_cell_1 <= '0;
      A_cell_2 <= '0;
      B_cell_1 <= '0;
      B_cell_2 <= '0;
      case (state)
        LOAD: begin
          if (accept) begin
            operand_buf[count] <= load_data;
            count              <= count + 3'd1;
            if (count == 3'd7) begin
              state      <= START;
              load_ready <= 1'b0;
              busy       <= 1'b1;
              mm_start   <= 1'b1;
            end
          end
        end
        START: begin
          state    <= FEED0;
          A_cell_1 <= operand_buf[0];
          B_cell_1 <= operand_buf[4];
        end
        FEED0: begin
          state    <= FEED1;
          A_cell_1 <= operand_buf[1];
          B_cell_1 <= operand_buf[6];
          A_cell_2 <= operand_buf[2];
          B_cell_2 <= operand_buf[5];
        end
        FEED1: begin
          state    <= FEED2;
          A_cell_2 <= operand_buf[3];
          B_cell_2 <= operand_buf[7];
        end
        FEED2: begin
          // All-zero flush cycle lets the delayed operands reach the bottom-right cell.
          state <= FEED3;
        end
        FEED3: begin
          state        <= DONE;
          busy         <= 1'b0;
          load_ready   <= 1'b1;
          result_valid <= 1'b1;
        end
        DONE: begin
          if (accept) begin
            operand_buf[0] <= load_data;
            count          <= 3'd1;
            state          <= LOAD;
            result_valid   <= 1'b0;
          end
        end
        default: begin
          state        <= LOAD;
          count        <= 3'd0;
          load_ready   <= 1'b1;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_feeder.sv
// Directed bench for matmul_feeder with a behavioural 2x2 output-stationary multiplier downstream.
module tb_matmul_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       mm_start;
  logic [7:0] A_cell_1, A_cell_2, B_cell_1, B_cell_2;
  logic       busy;
  logic       result_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matmul_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .mm_start     (mm_start),
    .A_cell_1     (A_cell_1),
    .A_cell_2     (A_cell_2),
    .B_cell_1     (B_cell_1),
    .B_cell_2     (B_cell_2),
    .busy         (busy),
    .result_valid (result_valid)
  );

  // Downstream multiplier: out1=C00, out2=C01, out3=C10, out4=C11, 16-bit wrapping accumulators.
  logic [15:0] acc [4];
  logic [7:0]  a_r00, b_r00, a_r10, b_r01;

  always @(posedge clk or posedge reset) begin
    if (reset || mm_start) begin
      for (int k = 0; k < 4; k++) acc[k] <= 16'd0;
      a_r00 <= 8'd0; b_r00 <= 8'd0; a_r10 <= 8'd0; b_r01 <= 8'd0;
    end else begin
      acc[0] <= acc[0] + 16'(A_cell_1) * 16'(B_cell_1);
      acc[1] <= acc[1] + 16'(a_r00) * 16'(B_cell_2);
      acc[2] <= acc[2] + 16'(A_cell_2) * 16'(b_r00);
      acc[3] <= acc[3] + 16'(a_r10) * 16'(b_r01);
      a_r00 <= A_cell_1;
      b_r00 <= B_cell_1;
      a_r10 <= A_cell_2;
      b_r01 <= B_cell_2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] v, input int i);
    return v[63-8*i -: 8];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, " load_ready"}, load_ready, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " mm_start"}, mm_start, 0);
    chk({tag, " result_valid"}, result_valid, 0);
    chk({tag, " buses"}, {A_cell_1, A_cell_2, B_cell_1, B_cell_2}, 0);
  endtask

  // Offers bytes lo..hi of v; leaves load_valid high with junk data when hold is set.
  task automatic load_range(input logic [63:0] v, input int lo, input int hi,
                            input int gap, input bit hold);
    for (int i = lo; i <= hi; i++) begin
      load_valid = 1'b1;
      load_data  = byte_of(v, i);
      @(posedge clk); #1;
      if (i != hi && gap > 0) begin
        load_valid = 1'b0;
        load_data  = 8'hEE;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    if (hold) load_data = 8'hEE;
    else load_valid = 1'b0;
  endtask

  // Called just after the edge accepting the last byte; ends at the negedge of the DONE cycle.
  task automatic run_check(input string tag, input logic [63:0] v,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    int rdy_low = 0;
    int busy_hi = 0;
    logic [7:0] ea1, ea2, eb1, eb2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) load_valid = 1'b0;
      ea1 = 8'd0; ea2 = 8'd0; eb1 = 8'd0; eb2 = 8'd0;
      case (c)
        2: begin ea1 = byte_of(v, 0); eb1 = byte_of(v, 4); end
        3: begin ea1 = byte_of(v, 1); eb1 = byte_of(v, 6);
                 ea2 = byte_of(v, 2); eb2 = byte_of(v, 5); end
        4: begin ea2 = byte_of(v, 3); eb2 = byte_of(v, 7); end
        default: ;
      endcase
      chk($sformatf("%s c%0d mm_start", tag, c), mm_start, (c == 1));
      chk($sformatf("%s c%0d A_cell_1", tag, c), A_cell_1, ea1);
      chk($sformatf("%s c%0d A_cell_2", tag, c), A_cell_2, ea2);
      chk($sformatf("%s c%0d B_cell_1", tag, c), B_cell_1, eb1);
      chk($sformatf("%s c%0d B_cell_2", tag, c), B_cell_2, eb2);
      chk($sformatf("%s c%0d result_valid", tag, c), result_valid, (c == 6));
      if (!load_ready) rdy_low++;
      if (busy) busy_hi++;
    end
    chk({tag, " ready_low_cycles"}, rdy_low, 5);
    chk({tag, " busy_cycles"}, busy_hi, 5);
    chk({tag, " out1"}, acc[0], e0);
    chk({tag, " out2"}, acc[1], e1);
    chk({tag, " out3"}, acc[2], e2);
    chk({tag, " out4"}, acc[3], e3);
  endtask

  initial begin
    logic [63:0] v;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b0;

    // Identity A times B from a freshly reset block.
    v = 64'h01000001_05060708;
    load_range(v, 0, 7, 0, 1'b0);
    run_check("identity", v, 16'd5, 16'd6, 16'd7, 16'd8);

    // General case, first byte accepted in the DONE cycle.
    v = 64'h01020304_05060708;
    load_valid = 1'b1;
    load_data  = byte_of(v, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b1 result_valid_fall", result_valid, 0);
    chk("b2b1 load_ready", load_ready, 1);
    chk("b2b1 busy", busy, 0);
    load_range(v, 1, 7, 0, 1'b0);
    run_check("general", v, 16'd19, 16'd22, 16'd43, 16'd50);

    // Overflow wraps in the multiplier: 2*255*255 mod 65536.
    v = 64'hFFFFFFFF_FFFFFFFF;
    load_range(v, 0, 7, 0, 1'b0);
    run_check("overflow", v, 16'd64514, 16'd64514, 16'd64514, 16'd64514);

    // Backpressure: gaps between bytes, load_valid held high with junk through START/FEED.
    v = 64'h01020304_01000001;
    load_range(v, 0, 7, 3, 1'b1);
    run_check("backpressure", v, 16'd1, 16'd2, 16'd3, 16'd4);

    // Back-to-back after backpressure: any stray stored byte would corrupt this result.
    v = 64'h03000102_01020304;
    load_valid = 1'b1;
    load_data  = byte_of(v, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b2 result_valid_fall", result_valid, 0);
    chk("b2b2 load_ready", load_ready, 1);
    load_range(v, 1, 7, 0, 1'b0);
    run_check("b2b2", v, 16'd3, 16'd6, 16'd7, 16'd10);

    // Reset asserted during FEED1 clears outputs at once; fresh load afterwards.
    v = 64'h09090909_09090909;
    load_range(v, 0, 7, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("midreset in_feed1 A_cell_2", A_cell_2, 8'h09);
    reset = 1'b1;
    #1;
    chk_idle("midreset");
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    v = 64'h02000002_01010101;
    load_range(v, 0, 7, 0, 1'b0);
    run_check("after_reset", v, 16'd2, 16'd2, 16'd2, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
